// File: rtl/fp16_pkg.sv
// FP16 field layout, special encodings and helpers shared by the quantizer.
// Contents: field positions/widths, FP16_BIAS, FP16_EXP_MAX, canonical NaN
// and +/-Inf encodings, the fp16_t struct, the element-kind enum and
// operand classification functions.
package fp16_pkg;

  localparam int unsigned FP16_W        = 16;
  localparam int unsigned FP16_SIGN_POS = 15;
  localparam int unsigned FP16_EXP_MSB  = 14;
  localparam int unsigned FP16_EXP_LSB  = 10;
  localparam int unsigned FP16_MANT_MSB = 9;
  localparam int unsigned FP16_MANT_LSB = 0;
  localparam int unsigned FP16_EXP_W    = 5;
  localparam int unsigned FP16_MANT_W   = 10;

  localparam int unsigned FP16_BIAS    = 15;
  localparam int unsigned FP16_EXP_MAX = 31;

  localparam logic [FP16_W-1:0] FP16_QNAN    = 16'h7E00;
  localparam logic [FP16_W-1:0] FP16_POS_INF = 16'h7C00;
  localparam logic [FP16_W-1:0] FP16_NEG_INF = 16'hFC00;

  // Product of two 11-bit significands and the exponent offset that makes
  // value = P * 2^(ea + eb - PROD_EXP_OFFS).
  localparam int unsigned PROD_W        = 22;
  localparam int unsigned PROD_EXP_OFFS = 2 * FP16_BIAS + 2 * FP16_MANT_W;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  expo;
    logic [FP16_MANT_W-1:0] mant;
  } fp16_t;

  // Result class decided in the first stage.
  typedef enum logic [1:0] {
    QK_ZERO = 2'd0,
    QK_SAT  = 2'd1,
    QK_NORM = 2'd2
  } qkind_e;

  // Subnormals are flushed, so exp==0 means zero.
  function automatic logic fp16_is_zero(input fp16_t x);
    return x.expo == '0;
  endfunction

  function automatic logic fp16_is_inf(input fp16_t x);
    return (x.expo == 5'(FP16_EXP_MAX)) && (x.mant == '0);
  endfunction

  function automatic logic fp16_is_nan(input fp16_t x);
    return (x.expo == 5'(FP16_EXP_MAX)) && (x.mant != '0);
  endfunction

endpackage

// File: rtl/rne_shift_sat.sv
// Combinational right shift with round-to-nearest-even and clamp.
// Ports:
//   p_i   [21:0]     significand product P
//   k_i   [5:0]      right shift amount; 0 means value >= P (always clamps)
//   mag_o [OUT_W-2:0] rounded magnitude, clamped to 2^(OUT_W-1)-1
//   sat_o            magnitude was clamped
module rne_shift_sat
  import fp16_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic [PROD_W-1:0] p_i,
  input  logic [5:0]        k_i,
  output logic [OUT_W-2:0]  mag_o,
  output logic              sat_o
);

  localparam int unsigned      RW   = PROD_W + 1;
  localparam logic [OUT_W-2:0] MAXV = '1;

  logic              in_range;
  logic [PROD_W-1:0] shifted;
  logic [PROD_W-1:0] guard_mask;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [RW-1:0]     rounded;

  always_comb begin
    in_range   = (k_i != '0) && (k_i <= 6'(PROD_W));
    shifted    = '0;
    guard_mask = '0;
    if (k_i == '0) begin
      shifted = p_i;
    end else if (in_range) begin
      shifted    = p_i >> k_i;
      guard_mask = PROD_W'(1) << (k_i - 6'd1);
    end
    // Sticky covers every bit below the guard position.
    guard    = |(p_i & guard_mask);
    sticky   = |(p_i & (guard_mask - PROD_W'(1))) & in_range;
    round_up = guard && (sticky || shifted[0]);
    rounded  = {1'b0, shifted} + RW'(round_up);
    sat_o    = rounded > RW'(MAXV);
    mag_o    = sat_o ? MAXV : rounded[OUT_W-2:0];
  end

endmodule

// File: rtl/fp16_quant_unit.sv
// Three-stage FP16 -> signed OUT_W-bit quantizer (x * inv_scale, RNE, clamp).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           input handshake
//   in_data, in_inv_scale       FP16 activation and inverse scale
//   in_last                     end-of-vector tag
//   out_valid/out_ready         output handshake
//   out_data [OUT_W-1:0]        signed result in [-MAXV, MAXV]
//   out_last, out_sat           aligned tag, clamp flag
//   sat_count [15:0], clr_stats saturating clamp counter and its clear
module fp16_quant_unit
  import fp16_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [15:0]      in_inv_scale,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_sat,
  output logic [15:0]      sat_count,
  input  logic             clr_stats
);

  localparam logic [OUT_W-2:0] MAXV = '1;

  fp16_t op_a;
  fp16_t op_b;
  logic  advance;

  // Stage 1: classify, multiply significands, sum exponents.
  qkind_e             s1_kind_d,  s1_kind_q;
  logic [PROD_W-1:0]  s1_prod_d,  s1_prod_q;
  logic signed [6:0]  s1_shift_d, s1_shift_q;
  logic               s1_valid_q, s1_last_q, s1_sign_q;

  // Stage 2: shift amount; rounding happens on its outputs.
  qkind_e             s2_kind_q;
  logic [PROD_W-1:0]  s2_prod_q;
  logic [5:0]         s2_k_d, s2_k_q;
  logic               s2_valid_q, s2_last_q, s2_sign_q;

  // Stage 3: clamp, sign, output registers.
  logic [OUT_W-2:0]   rnd_mag;
  logic               rnd_sat;
  logic [OUT_W-2:0]   mag_d;
  logic               sat_d;
  logic [OUT_W-1:0]   data_d;
  logic               out_valid_q, out_last_q, out_sat_q;
  logic [OUT_W-1:0]   out_data_q;
  logic [15:0]        cnt_q;
  logic               cnt_inc;

  assign op_a     = in_data;
  assign op_b     = in_inv_scale;
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    s1_kind_d = QK_NORM;
    if (fp16_is_nan(op_a) || fp16_is_nan(op_b)) begin
      s1_kind_d = QK_ZERO;
    end else if (fp16_is_inf(op_a) || fp16_is_inf(op_b)) begin
      s1_kind_d = (fp16_is_zero(op_a) || fp16_is_zero(op_b)) ? QK_ZERO : QK_SAT;
    end else if (fp16_is_zero(op_a) || fp16_is_zero(op_b)) begin
      s1_kind_d = QK_ZERO;
    end
  end

  assign s1_prod_d  = PROD_W'({1'b1, op_a.mant}) * PROD_W'({1'b1, op_b.mant});
  assign s1_shift_d = $signed({2'b00, op_a.expo}) + $signed({2'b00, op_b.expo})
                    - $signed(7'(PROD_EXP_OFFS));

  // A non-negative exponent sum maps to k=0, which the rounder always clamps.
  assign s2_k_d = s1_shift_q[6] ? 6'(-s1_shift_q) : '0;

  rne_shift_sat #(
    .OUT_W(OUT_W)
  ) u_rne (
    .p_i   (s2_prod_q),
    .k_i   (s2_k_q),
    .mag_o (rnd_mag),
    .sat_o (rnd_sat)
  );

  always_comb begin
    mag_d = '0;
    sat_d = 1'b0;
    case (s2_kind_q)
      QK_SAT: begin
        mag_d = MAXV;
        sat_d = 1'b1;
      end
      QK_NORM: begin
        mag_d = rnd_mag;
        sat_d = rnd_sat;
      end
      default: ;
    endcase
    // Negating a zero magnitude stays zero, so -0 never appears.
    data_d = s2_sign_q ? -{1'b0, mag_d} : {1'b0, mag_d};
  end

  assign cnt_inc = advance && s2_valid_q && sat_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_kind_q   <= QK_ZERO;
      s1_prod_q   <= '0;
      s1_shift_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_kind_q   <= QK_ZERO;
      s2_prod_q   <= '0;
      s2_k_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_last_q   <= in_last;
      s1_sign_q   <= op_a.sign ^ op_b.sign;
      s1_kind_q   <= s1_kind_d;
      s1_prod_q   <= s1_prod_d;
      s1_shift_q  <= s1_shift_d;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_sign_q   <= s1_sign_q;
      s2_kind_q   <= s1_kind_q;
      s2_prod_q   <= s1_prod_q;
      s2_k_q      <= s2_k_d;
      out_valid_q <= s2_valid_q;
      out_data_q  <= s2_valid_q ? data_d : '0;
      out_last_q  <= s2_valid_q && s2_last_q;
      out_sat_q   <= s2_valid_q && sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_stats) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_fp16_quant_unit.sv
// Self-checking bench for fp16_quant_unit: real-arithmetic reference model,
// scoreboard queue, directed corner cases and randomized streams.
module tb_fp16_quant_unit;

  localparam int unsigned OUT_W = 8;
  localparam int          MAXV  = (1 << (OUT_W - 1)) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = '0;
  logic [15:0]      in_inv_scale = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             out_sat;
  logic [15:0]      sat_count;
  logic             clr_stats = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int val;
    bit sat;
    bit last;
    int acc;
  } exp_t;
  exp_t q[$];

  int popped = 0;
  int lasts_seen = 0;
  int sat_pushed = 0;
  int last_lat = 0;
  bit head_seen = 0;
  bit rand_rdy = 0;

  fp16_quant_unit #(
    .OUT_W(OUT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_inv_scale (in_inv_scale),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_sat      (out_sat),
    .sat_count    (sat_count),
    .clr_stats    (clr_stats)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Magnitude of a normal FP16 number: (1024 + mant) * 2^(exp - 25).
  function automatic real fp_mag(input logic [15:0] x);
    real v;
    int  sh;
    v  = 1024.0 + real'(x[9:0]);
    sh = int'(x[14:10]) - 25;
    if (sh > 0) repeat (sh) v = v * 2.0;
    else        repeat (-sh) v = v / 2.0;
    return v;
  endfunction

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output int val, output bit sat);
    bit  az, an, ai, bz, bn, bi, neg;
    real m, r, f;
    int  mi;
    az  = (a[14:10] == 5'd0);
    an  = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
    ai  = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
    bz  = (b[14:10] == 5'd0);
    bn  = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
    bi  = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
    neg = a[15] ^ b[15];
    val = 0;
    sat = 0;
    if (an || bn) return;
    if (ai || bi) begin
      if (az || bz) return;
      sat = 1;
      val = neg ? -MAXV : MAXV;
      return;
    end
    if (az || bz) return;
    m = fp_mag(a) * fp_mag(b);
    if (m >= 65536.0) begin
      mi = MAXV + 1;
    end else begin
      r  = $floor(m);
      f  = m - r;
      mi = int'(r);
      if (f > 0.5 || (f == 0.5 && (mi % 2) == 1)) mi++;
    end
    if (mi > MAXV) begin
      mi  = MAXV;
      sat = 1;
    end
    val = neg ? -mi : mi;
  endfunction

  // Scoreboard: push on accept, compare every cycle out_valid is high.
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic             prev_last, prev_sat;
  initial forever begin
    int v;
    bit s;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        model(in_data, in_inv_scale, v, s);
        q.push_back('{v, s, in_last, cyc});
        if (s) sat_pushed++;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", $signed(out_data), $signed(prev_data));
        check("stall_last", out_last, prev_last);
        check("stall_sat", out_sat, prev_sat);
      end
      if (out_valid) begin
        check("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          if (!head_seen) begin
            last_lat  = cyc - q[0].acc;
            head_seen = 1;
          end
          check("out_data", $signed(out_data), q[0].val);
          check("out_sat", out_sat, q[0].sat);
          check("out_last", out_last, q[0].last);
          if (out_ready) begin
            if (out_last) lasts_seen++;
            void'(q.pop_front());
            popped++;
            head_seen = 0;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_sat   = out_sat;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 99) < 60);
  end

  // All driving tasks start and end at posedge + 1.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    bit acc;
    int w;
    acc          = 0;
    w            = 0;
    in_valid     = 1'b1;
    in_data      = a;
    in_inv_scale = b;
    in_last      = last;
    while (!acc && w < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      w++;
    end
    check("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((q.size() != 0 || out_valid) && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check({name, "_drain"}, q.size(), 0);
  endtask

  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                         input int exp_val, input bit exp_sat);
    int mv;
    bit ms;
    int w;
    model(a, b, mv, ms);
    check({name, "_model"}, mv, exp_val);
    check({name, "_model_sat"}, ms, exp_sat);
    send(a, b, 1'b0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, $signed(out_data), exp_val);
    check({name, "_sat"}, out_sat, exp_sat);
    @(negedge clk);
    #1;
    check({name, "_latency"}, last_lat, 3);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_fp();
    int unsigned r;
    logic [15:0] x;
    r = $urandom_range(0, 99);
    x = 16'($urandom);
    if (r < 75)      x[14:10] = 5'($urandom_range(8, 22));
    else if (r < 82) begin
      x[14:10] = 5'd31;
      if (r < 78) x[9:0] = '0;
    end else if (r < 88) x[14:10] = 5'd0;
    return x;
  endfunction

  logic [15:0] vec[8] = '{16'h4500, 16'h4100, 16'hC300, 16'h5A40,
                          16'h3800, 16'hFC00, 16'h4A00, 16'h0001};

  initial begin
    int p0, l0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    run_one("five",     16'h4500, 16'h3C00, 5, 0);
    run_one("tie_2p5",  16'h4100, 16'h3C00, 2, 0);
    run_one("tie_3p5",  16'h4300, 16'h3C00, 4, 0);
    run_one("tie_m2p5", 16'hC100, 16'h3C00, -2, 0);
    run_one("quarter",  16'h3800, 16'h3800, 0, 0);
    run_one("clamp200", 16'h5A40, 16'h3C00, 127, 1);
    check("cnt_after_200", sat_count, 1);
    run_one("neg_inf",  16'hFC00, 16'h3C00, -127, 1);
    check("cnt_after_inf", sat_count, 2);
    run_one("nan",      16'h7E00, 16'h3C00, 0, 0);
    run_one("subnorm",  16'h0001, 16'h3C00, 0, 0);
    run_one("inf_zero", 16'h7C00, 16'h0000, 0, 0);
    run_one("one_inf",  16'h3C00, 16'h7C00, 127, 1);
    run_one("edge127",  16'h57F0, 16'h3C00, 127, 0);
    run_one("tie127p5", 16'h57F8, 16'h3C00, 127, 1);
    check("cnt_after_dir", sat_count, 4);

    // Clear lands on the same edge a saturating element is captured.
    check("clr_pre_nonzero", sat_count != 0, 1);
    send(16'h5A40, 16'h3C00, 1'b0);
    @(posedge clk);
    #1;
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    check("clr_cap_valid", out_valid, 1);
    check("clr_cap_sat", out_sat, 1);
    check("clr_wins", sat_count, 0);
    drain("clr");

    // 8-element vector under random backpressure.
    p0 = popped;
    l0 = lasts_seen;
    rand_rdy = 1;
    for (int i = 0; i < 8; i++) send(vec[i], 16'h4200, i == 7);
    drain("vec");
    check("vec_count", popped - p0, 8);
    check("vec_lasts", lasts_seen - l0, 1);

    // Random stream with gaps and backpressure.
    @(posedge clk);
    #1;
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats  = 1'b0;
    sat_pushed = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rnd_fp(), rnd_fp(), $urandom_range(0, 7) == 0);
    end
    drain("rand");
    check("rand_sat_count", sat_count, sat_pushed);
    rand_rdy = 0;
    out_ready = 1'b1;

    // Reset with three elements in flight.
    @(posedge clk);
    #1;
    send(16'h4500, 16'h3C00, 1'b1);
    send(16'h5A40, 16'h3C00, 1'b0);
    send(16'h4300, 16'h3C00, 1'b0);
    check("inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_last", out_last, 0);
    check("midrst_sat", out_sat, 0);
    check("midrst_cnt", sat_count, 0);
    q.delete();
    head_seen = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("no_stale_valid", out_valid, 0);
    end
    run_one("post_rst", 16'h4500, 16'h3C00, 5, 0);

    // Drive sat_count to its ceiling, then one more clamp.
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    for (int i = 0; i < 65535; i++) send(16'hFC00, 16'h3C00, 1'b0);
    drain("bulk");
    check("cnt_ceiling", sat_count, 16'hFFFF);
    send(16'h5A40, 16'h3C00, 1'b0);
    drain("bulk_extra");
    check("cnt_holds", sat_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
